lane_target_game: RTL and testbench

//  Parametrised successor of the dot-matrix target game core: LANES target lanes

---
 rtl/lane_target_game.sv | 279 +++++++++++++++++++++++++++
 tb/tb_lane_target_game.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_target_game.sv
// Scrolling-lane target game core: game FSM, BCD score, countdown,
// miss counter, LFSR target spawn and LED matrix row scan.
module lane_target_game #(
  parameter int LANES    = 3,
  parameter int LANE_H   = 2,
  parameter int COLS     = 16,
  parameter int MODE     = 0,
  parameter int TICK_DIV = 50000000,
  parameter int STEP_DIV = 15000000,
  parameter int SCAN_DIV = 5000,
  parameter int LED_STEP = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       level,
  input  logic [LANES-1:0] hit,
  output logic [1:0]       state,
  output logic [11:0]      score_bcd,
  output logic [7:0]       countdown,
  output logic [7:0]       misses,
  output logic [9:0]       led,
  output logic [7:0]       dot_row,
  output logic [COLS-1:0]  dot_col
);

  localparam int ROWS = LANES * LANE_H;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [11:0]                 score_q, score_d;
  logic [9:0]                  score_bin_q, score_bin_d;
  logic [7:0]                  countdown_q, countdown_d;
  logic [7:0]                  misses_q, misses_d;
  logic [LANES-1:0][COLS-1:0]  lanes_q, lanes_d;
  logic [TW-1:0]               tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]               step_cnt_q, step_cnt_d;
  logic [CW-1:0]               scan_cnt_q, scan_cnt_d;
  logic [2:0]                  row_q, row_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [7:0]                  dot_row_q, dot_row_d;
  logic [COLS-1:0]             dot_col_q, dot_col_d;
  logic                        start_r1_q, start_r1_d;
  logic                        start_r2_q, start_r2_d;
  logic [LANES-1:0]            hit_r1_q, hit_r1_d;
  logic [LANES-1:0]            hit_r2_q, hit_r2_d;

  logic                        start_e;
  logic [LANES-1:0]            hit_e;
  logic                        hit_any;
  int                          hit_k;
  int                          spawn_k;
  logic                        do_init;
  logic                        valid;
  logic                        do_shift;
  logic                        do_spawn;
  logic [3:0]                  miss_add;
  logic [8:0]                  miss_sum;
  logic [7:0]                  lvl_bcd;
  logic [LANES-1:0][COLS-1:0]  lanes_n;

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    score_bin_d = score_bin_q;
    countdown_d = countdown_q;
    misses_d    = misses_q;
    lanes_d     = lanes_q;
    tick_cnt_d  = tick_cnt_q;
    step_cnt_d  = step_cnt_q;
    scan_cnt_d  = scan_cnt_q;
    row_d       = row_q;
    dot_row_d   = dot_row_q;
    dot_col_d   = dot_col_q;
    lfsr_d      = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    start_r1_d  = start;
    start_r2_d  = start_r1_q;
    hit_r1_d    = hit;
    hit_r2_d    = hit_r1_q;
    start_e     = start_r1_q & ~start_r2_q;
    hit_e       = hit_r1_q & ~hit_r2_q;
    hit_any     = 1'b0;
    hit_k       = 0;
    spawn_k     = int'(lfsr_q[7:0]) % LANES;
    do_init     = 1'b0;
    valid       = 1'b0;
    do_shift    = 1'b0;
    do_spawn    = 1'b0;
    miss_add    = '0;
    miss_sum    = '0;
    lanes_n     = lanes_q;

    unique case (level)
      2'd0:    lvl_bcd = 8'h30;
      2'd1:    lvl_bcd = 8'h60;
      2'd2:    lvl_bcd = 8'h90;
      default: lvl_bcd = 8'h99;
    endcase

    // Lowest-numbered lane wins when several keys rise together
    for (int k = LANES - 1; k >= 0; k--) begin
      if (hit_e[k]) begin
        hit_any = 1'b1;
        hit_k   = k;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        countdown_d = lvl_bcd;
        do_init     = start_e;
      end
      S_PLAY: begin
        if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
          tick_cnt_d = '0;
          if (countdown_q == 8'h01 || countdown_q == 8'h00) begin
            countdown_d = 8'h00;
            state_d     = S_OVER;
          end else if (countdown_q[3:0] == 4'd0) begin
            countdown_d = {countdown_q[7:4] - 4'd1, 4'd9};
          end else begin
            countdown_d = countdown_q - 8'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end

        for (int k = 0; k < LANES; k++) begin
          if (hit_any && k == hit_k) begin
            if (lanes_n[k][0]) begin
              valid         = 1'b1;
              lanes_n[k][0] = 1'b0;
            end else begin
              miss_add = miss_add + 4'd1;
            end
          end
        end

        if (valid && MODE == 0) begin
          do_shift = 1'b1;
          do_spawn = 1'b1;
        end

        // Step sees lanes after the hit was cleared
        if (MODE == 1) begin
          if (step_cnt_q == SW'(STEP_DIV - 1)) begin
            step_cnt_d = '0;
            do_shift   = 1'b1;
            do_spawn   = lfsr_q[8];
            for (int k = 0; k < LANES; k++) begin
              miss_add = miss_add + {3'd0, lanes_n[k][0]};
            end
          end else begin
            step_cnt_d = step_cnt_q + SW'(1);
          end
        end

        for (int k = 0; k < LANES; k++) begin
          if (do_shift) lanes_n[k] = lanes_n[k] >> 1;
          if (do_spawn && k == spawn_k) lanes_n[k][COLS-1] = 1'b1;
        end
        lanes_d = lanes_n;

        miss_sum = {1'b0, misses_q} + {5'd0, miss_add};
        misses_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];

        if (valid && score_bin_q != 10'd999) begin
          score_bin_d = score_bin_q + 10'd1;
          if (score_q[3:0] != 4'd9) begin
            score_d[3:0] = score_q[3:0] + 4'd1;
          end else begin
            score_d[3:0] = 4'd0;
            if (score_q[7:4] != 4'd9) begin
              score_d[7:4] = score_q[7:4] + 4'd1;
            end else begin
              score_d[7:4]  = 4'd0;
              score_d[11:8] = score_q[11:8] + 4'd1;
            end
          end
        end
      end
      S_OVER: begin
        do_init = start_e;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_init) begin
      state_d     = S_PLAY;
      score_d     = '0;
      score_bin_d = '0;
      misses_d    = '0;
      tick_cnt_d  = '0;
      step_cnt_d  = '0;
      countdown_d = lvl_bcd;
      for (int k = 0; k < LANES; k++) begin
        lanes_d[k]      = '0;
        lanes_d[k][3*k] = 1'b1;
      end
    end

    if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dot_row_d  = ~(8'h80 >> row_q);
      for (int k = 0; k < LANES; k++) begin
        if (int'(row_q) / LANE_H == k) dot_col_d = lanes_q[k];
      end
      row_d = (row_q == 3'(ROWS - 1)) ? 3'd0 : row_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      score_bin_q <= '0;
      countdown_q <= 8'h30;
      misses_q    <= '0;
      lanes_q     <= '0;
      tick_cnt_q  <= '0;
      step_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      row_q       <= '0;
      lfsr_q      <= 16'hACE1;
      dot_row_q   <= 8'hFF;
      dot_col_q   <= '0;
      start_r1_q  <= 1'b0;
      start_r2_q  <= 1'b0;
      hit_r1_q    <= '0;
      hit_r2_q    <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      score_bin_q <= score_bin_d;
      countdown_q <= countdown_d;
      misses_q    <= misses_d;
      lanes_q     <= lanes_d;
      tick_cnt_q  <= tick_cnt_d;
      step_cnt_q  <= step_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      row_q       <= row_d;
      lfsr_q      <= lfsr_d;
      dot_row_q   <= dot_row_d;
      dot_col_q   <= dot_col_d;
      start_r1_q  <= start_r1_d;
      start_r2_q  <= start_r2_d;
      hit_r1_q    <= hit_r1_d;
      hit_r2_q    <= hit_r2_d;
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < 10; i++) begin
      led[i] = (int'(score_bin_q) >= (i + 1) * LED_STEP);
    end
  end

  assign state     = state_q;
  assign score_bcd = score_q;
  assign countdown = countdown_q;
  assign misses    = misses_q;
  assign dot_row   = dot_row_q;
  assign dot_col   = dot_col_q;

endmodule

// File: tb/tb_lane_target_game.sv
// Bench for lane_target_game: MODE 0 and MODE 1 instances share stimulus
// and are checked against an integer-level game model.
module tb_lane_target_game;

  localparam int TD = 20;
  localparam int SD = 8;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] level = 2'd1;
  logic [2:0] hit = 3'd0;

  logic [1:0]  st_o[2];
  logic [11:0] sc_o[2];
  logic [7:0]  cd_o[2];
  logic [7:0]  ms_o[2];
  logic [9:0]  led_o[2];
  logic [7:0]  dr_o[2];
  logic [15:0] dc_o[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_target_game #(.MODE(0), .TICK_DIV(TD), .STEP_DIV(SD),
                     .SCAN_DIV(SC)) u0 (
    .clk(clk), .reset(reset), .start(start), .level(level), .hit(hit),
    .state(st_o[0]), .score_bcd(sc_o[0]), .countdown(cd_o[0]),
    .misses(ms_o[0]), .led(led_o[0]), .dot_row(dr_o[0]),
    .dot_col(dc_o[0]));

  lane_target_game #(.MODE(1), .TICK_DIV(TD), .STEP_DIV(SD),
                     .SCAN_DIV(SC)) u1 (
    .clk(clk), .reset(reset), .start(start), .level(level), .hit(hit),
    .state(st_o[1]), .score_bcd(sc_o[1]), .countdown(cd_o[1]),
    .misses(ms_o[1]), .led(led_o[1]), .dot_row(dr_o[1]),
    .dot_col(dc_o[1]));

  typedef struct packed {
    int                 st;
    int                 score;
    int                 cd;
    int                 miss;
    int                 tick;
    int                 stepc;
    logic [2:0][15:0]   lanes;
    logic [15:0]        col;
  } mdl_t;

  mdl_t        m[2];
  logic        s1, s2;
  logic [2:0]  h1, h2;
  logic [15:0] lf;
  int          scnt, row;
  logic [7:0]  erow;

  function automatic int lvsec(logic [1:0] l);
    case (l)
      2'd0:    return 30;
      2'd1:    return 60;
      2'd2:    return 90;
      default: return 99;
    endcase
  endfunction

  function automatic logic [7:0] bcd2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] bcd3(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [9:0] bar(int s);
    logic [9:0] b;
    for (int i = 0; i < 10; i++) b[i] = (s >= (i + 1) * 20);
    return b;
  endfunction

  function automatic mdl_t mstep(mdl_t a, int mode, logic se,
                                 logic [2:0] he, logic [15:0] l,
                                 logic [1:0] lv);
    mdl_t n;
    int   k, sp, add;
    logic ok, sh, spn;
    n = a; sp = int'(l[7:0]) % 3; add = 0; k = -1;
    ok = 1'b0; sh = 1'b0; spn = 1'b0;
    if (a.st == 0) n.cd = lvsec(lv);
    if (a.st == 1) begin
      if (a.tick == TD - 1) begin
        n.tick = 0;
        if (a.cd <= 1) begin n.cd = 0; n.st = 2; end
        else n.cd = a.cd - 1;
      end else n.tick = a.tick + 1;
      for (int i = 2; i >= 0; i--) if (he[i]) k = i;
      for (int i = 0; i < 3; i++) begin
        if (i == k) begin
          if (n.lanes[i][0]) begin ok = 1'b1; n.lanes[i][0] = 1'b0; end
          else add = add + 1;
        end
      end
      if (ok) begin
        if (n.score < 999) n.score = n.score + 1;
        if (mode == 0) begin sh = 1'b1; spn = 1'b1; end
      end
      if (mode == 1) begin
        if (a.stepc == SD - 1) begin
          n.stepc = 0; sh = 1'b1; spn = l[8];
          for (int i = 0; i < 3; i++) add = add + int'(n.lanes[i][0]);
        end else n.stepc = a.stepc + 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (sh) n.lanes[i] = n.lanes[i] >> 1;
        if (spn && i == sp) n.lanes[i][15] = 1'b1;
      end
      n.miss = (a.miss + add > 255) ? 255 : a.miss + add;
    end else if (se) begin
      n.st = 1; n.score = 0; n.miss = 0; n.tick = 0; n.stepc = 0;
      n.cd = lvsec(lv);
      for (int i = 0; i < 3; i++) n.lanes[i] = 16'd1 << (3 * i);
    end
    return n;
  endfunction

  task automatic cyc();
    logic             se;
    logic [2:0]       he;
    logic [2:0][15:0] old[2];
    @(posedge clk);
    if (reset) begin
      s1 = 1'b0; s2 = 1'b0; h1 = '0; h2 = '0; lf = 16'hACE1;
      scnt = 0; row = 0; erow = 8'hFF;
      for (int i = 0; i < 2; i++) begin m[i] = '0; m[i].cd = 30; end
    end else begin
      se = s1 & ~s2; he = h1 & ~h2;
      for (int i = 0; i < 2; i++) begin
        old[i] = m[i].lanes;
        m[i] = mstep(m[i], i, se, he, lf, level);
      end
      if (scnt == SC - 1) begin
        scnt = 0; erow = ~(8'h80 >> row);
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 3; j++)
            if (j == row / 2) m[i].col = old[i][j];
        row = (row == 5) ? 0 : row + 1;
      end else scnt = scnt + 1;
      s2 = s1; s1 = start; h2 = h1; h1 = hit;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    #1;
  endtask

  task automatic new_game(logic [1:0] lv);
    reset = 1'b1; start = 1'b0; hit = '0; level = lv;
    cyc(); cyc();
    reset = 1'b0; cyc();
    start = 1'b1; cyc(); cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (st_o[i] !== 2'd1) begin
        errors++; $display("FAIL game_start[%0d]: got %0d want 1", i, st_o[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] seq[6];
    logic [7:0] prev;
    int         idx;
    seq = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB};
    reset = 1'b1; level = 2'd1; start = 1'b0; hit = '0;
    repeat (3) cyc();
    for (int i = 0; i < 2; i++) begin
      checks += 7;
      if (st_o[i] !== 2'd0) begin errors++;
        $display("FAIL reset_state[%0d]: got %h want 0", i, st_o[i]); end
      if (sc_o[i] !== 12'h000) begin errors++;
        $display("FAIL reset_score[%0d]: got %h want 000", i, sc_o[i]); end
      if (cd_o[i] !== 8'h30) begin errors++;
        $display("FAIL reset_cd[%0d]: got %h want 30", i, cd_o[i]); end
      if (ms_o[i] !== 8'h00) begin errors++;
        $display("FAIL reset_miss[%0d]: got %h want 00", i, ms_o[i]); end
      if (led_o[i] !== 10'h000) begin errors++;
        $display("FAIL reset_led[%0d]: got %h want 000", i, led_o[i]); end
      if (dr_o[i] !== 8'hFF) begin errors++;
        $display("FAIL reset_row[%0d]: got %h want FF", i, dr_o[i]); end
      if (dc_o[i] !== 16'h0000) begin errors++;
        $display("FAIL reset_col[%0d]: got %h want 0000", i, dc_o[i]); end
    end
    reset = 1'b0; cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cd_o[i] !== 8'h60) begin errors++;
        $display("FAIL level_cd[%0d]: got %h want 60", i, cd_o[i]); end
    end
    prev = 8'hFF; idx = 0;
    for (int t = 0; t < 60; t++) begin
      cyc();
      if (dr_o[0] !== prev) begin
        checks++;
        if (dr_o[0] !== seq[idx % 6]) begin errors++;
          $display("FAIL scan_seq: got %h want %h", dr_o[0], seq[idx % 6]); end
        idx++; prev = dr_o[0];
      end
      checks++;
      if (dr_o[1] !== erow) begin errors++;
        $display("FAIL scan_row1: got %h want %h", dr_o[1], erow); end
    end
    checks++;
    if (idx < 12) begin errors++;
      $display("FAIL scan_steps: got %0d want >=12", idx); end
  endtask

  task automatic test_hit_valid();
    new_game(2'd1);
    hit = 3'b001; cyc(); cyc(); hit = '0;
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (sc_o[i] !== 12'h001) begin errors++;
        $display("FAIL valid_score[%0d]: got %h want 001", i, sc_o[i]); end
      if (ms_o[i] !== 8'h00) begin errors++;
        $display("FAIL valid_miss[%0d]: got %h want 00", i, ms_o[i]); end
    end
    repeat (24) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dc_o[i] !== m[i].col) begin errors++;
          $display("FAIL valid_col[%0d]: got %h want %h", i, dc_o[i], m[i].col); end
      end
    end
  endtask

  task automatic test_miss();
    new_game(2'd1);
    hit = 3'b010; cyc(); cyc(); hit = '0;
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (ms_o[i] !== 8'h01) begin errors++;
        $display("FAIL miss_count[%0d]: got %h want 01", i, ms_o[i]); end
      if (sc_o[i] !== 12'h000) begin errors++;
        $display("FAIL miss_score[%0d]: got %h want 000", i, sc_o[i]); end
    end
  endtask

  task automatic test_multi_hit();
    new_game(2'd1);
    hit = 3'b011; cyc(); cyc(); hit = '0;
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (sc_o[i] !== 12'h001) begin errors++;
        $display("FAIL multi_score[%0d]: got %h want 001", i, sc_o[i]); end
      if (ms_o[i] !== 8'h00) begin errors++;
        $display("FAIL multi_miss[%0d]: got %h want 00", i, ms_o[i]); end
    end
  endtask

  task automatic test_mode1_step();
    new_game(2'd1);
    repeat (8) cyc();
    checks += 2;
    if (ms_o[1] !== 8'h01) begin errors++;
      $display("FAIL step_miss1: got %h want 01", ms_o[1]); end
    if (ms_o[0] !== 8'h00) begin errors++;
      $display("FAIL step_miss0: got %h want 00", ms_o[0]); end
    repeat (24) begin
      cyc();
      checks++;
      if (dc_o[1] !== m[1].col) begin errors++;
        $display("FAIL step_col: got %h want %h", dc_o[1], m[1].col); end
    end
  endtask

  task automatic test_random();
    new_game(2'd2);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 2) == 0) hit = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) start = ~start;
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks += 7;
        if (st_o[i] !== 2'(m[i].st)) begin errors++;
          $display("FAIL rnd_state[%0d]: got %0d want %0d", i, st_o[i], m[i].st); end
        if (sc_o[i] !== bcd3(m[i].score)) begin errors++;
          $display("FAIL rnd_score[%0d]: got %h want %h", i, sc_o[i], bcd3(m[i].score)); end
        if (cd_o[i] !== bcd2(m[i].cd)) begin errors++;
          $display("FAIL rnd_cd[%0d]: got %h want %h", i, cd_o[i], bcd2(m[i].cd)); end
        if (ms_o[i] !== 8'(m[i].miss)) begin errors++;
          $display("FAIL rnd_miss[%0d]: got %0d want %0d", i, ms_o[i], m[i].miss); end
        if (led_o[i] !== bar(m[i].score)) begin errors++;
          $display("FAIL rnd_led[%0d]: got %h want %h", i, led_o[i], bar(m[i].score)); end
        if (dr_o[i] !== erow) begin errors++;
          $display("FAIL rnd_row[%0d]: got %h want %h", i, dr_o[i], erow); end
        if (dc_o[i] !== m[i].col) begin errors++;
          $display("FAIL rnd_col[%0d]: got %h want %h", i, dc_o[i], m[i].col); end
      end
    end
    hit = '0; start = 1'b0;
  endtask

  task automatic test_game_over();
    logic [7:0] prev;
    int         nchg;
    int         sv_ms[2];
    int         sv_sc[2];
    new_game(2'd0);
    prev = 8'h30; nchg = 0;
    for (int t = 0; t < 30 * TD + 100 && m[0].st != 2; t++) begin
      if (hit != 3'd0) hit = '0;
      else if (m[1].score < 20 && m[1].stepc <= 5) begin
        for (int k = 2; k >= 0; k--) if (m[1].lanes[k][0]) hit = 3'd1 << k;
      end
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (cd_o[i] !== bcd2(m[i].cd)) begin errors++;
          $display("FAIL over_cd[%0d]: got %h want %h", i, cd_o[i], bcd2(m[i].cd)); end
      end
      if (cd_o[0] !== prev) begin nchg++; prev = cd_o[0]; end
    end
    hit = '0;
    checks += 3;
    if (nchg !== 30) begin errors++;
      $display("FAIL over_ticks: got %0d want 30", nchg); end
    if (sc_o[1] !== 12'h020) begin errors++;
      $display("FAIL over_score: got %h want 020", sc_o[1]); end
    if (led_o[1] !== 10'b1) begin errors++;
      $display("FAIL over_led: got %b want 0000000001", led_o[1]); end
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (st_o[i] !== 2'd2) begin errors++;
        $display("FAIL over_state[%0d]: got %0d want 2", i, st_o[i]); end
      if (cd_o[i] !== 8'h00) begin errors++;
        $display("FAIL over_cd0[%0d]: got %h want 00", i, cd_o[i]); end
      sv_ms[i] = m[i].miss; sv_sc[i] = m[i].score;
    end
    repeat (4) begin
      hit = 3'b111; cyc(); cyc(); hit = 3'b001; cyc(); hit = '0; cyc();
    end
    for (int i = 0; i < 2; i++) begin
      checks += 3;
      if (ms_o[i] !== 8'(sv_ms[i])) begin errors++;
        $display("FAIL frozen_miss[%0d]: got %0d want %0d", i, ms_o[i], sv_ms[i]); end
      if (sc_o[i] !== bcd3(sv_sc[i])) begin errors++;
        $display("FAIL frozen_score[%0d]: got %h want %h", i, sc_o[i], bcd3(sv_sc[i])); end
      if (dc_o[i] !== m[i].col) begin errors++;
        $display("FAIL frozen_col[%0d]: got %h want %h", i, dc_o[i], m[i].col); end
    end
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks += 3;
      if (st_o[i] !== 2'd1) begin errors++;
        $display("FAIL restart_state[%0d]: got %0d want 1", i, st_o[i]); end
      if (sc_o[i] !== 12'h000) begin errors++;
        $display("FAIL restart_score[%0d]: got %h want 000", i, sc_o[i]); end
      if (ms_o[i] !== 8'h00) begin errors++;
        $display("FAIL restart_miss[%0d]: got %h want 00", i, ms_o[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_hit_valid();
    test_miss();
    test_multi_hit();
    test_mode1_step();
    test_random();
    test_game_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
